// File: rtl/pcie_to_pc_fifo.sv
// rtl/pcie_to_pc_fifo.sv - user stream to host: ring of 512-byte blocks, each sent as a 64-beat posted write
module pcie_to_pc_fifo #(
  parameter int         NBLOCKS_LOG2 = 3,
  parameter logic [3:0] STOP_ADDR    = 4'd6,
  parameter logic [3:0] INT_ADDR     = 4'd7
) (
  input  logic        clock,
  input  logic        reset,
  output logic [1:0]  interrupt,
  output logic [31:0] status,
  input  logic        pio_wvalid,
  input  logic [63:0] pio_wdata,
  input  logic [3:0]  pio_addr,
  input  logic        i_valid,
  input  logic [63:0] i_data,
  output logic        i_ready,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [63:0] wr_addr,
  output logic [63:0] wr_data,
  output logic        wr_last
);
  localparam int AW    = NBLOCKS_LOG2 + 6;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] BLK  = (AW+1)'(64);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  logic [63:0]   mem [DEPTH];
  state_t        state_q;
  logic [AW-1:0] fill_q, rd_q, rd_d;
  logic [AW:0]   occ_q, occ_d;
  logic [16:0]   p_write_q, p_write_d, p_stop_q, p_stop_d, p_int_q, p_int_d;
  logic [5:0]    beat_q;
  logic [63:0]   ram_q, out_q;
  logic          valid_q, last_q;
  logic [1:0]    irq_q;
  logic          accept, beat_ok, release_blk;
  logic          unused_pio;

  assign unused_pio  = ^{pio_wdata[63:26], pio_wdata[8:0]};
  assign i_ready     = (occ_q != FULL);
  assign accept      = i_valid && i_ready;
  assign beat_ok     = valid_q && wr_ready;
  assign release_blk = beat_ok && last_q;

  assign interrupt = irq_q;
  assign status    = {6'd0, p_write_q, 9'd0};
  assign wr_addr   = {38'd0, p_write_q, 9'd0};
  assign wr_data   = out_q;
  assign wr_valid  = valid_q;
  assign wr_last   = last_q;

  // rd_q is the next word to move into the output register; it stops on the block boundary
  always_comb begin
    rd_d = rd_q;
    if (state_q == LOAD || (beat_ok && !last_q))
      rd_d = rd_q + 1'b1;
    p_write_d = p_write_q + (release_blk ? 17'd1 : 17'd0);
    p_stop_d  = (pio_wvalid && pio_addr == STOP_ADDR) ? pio_wdata[25:9] : p_stop_q;
    p_int_d   = (pio_wvalid && pio_addr == INT_ADDR)  ? pio_wdata[25:9] : p_int_q;
    occ_d     = occ_q + {{AW{1'b0}}, accept} - (release_blk ? BLK : '0);
  end

  // ram_q always holds the word after the one on the bus, so a stall simply re-reads it
  always_ff @(posedge clock) begin
    if (accept)
      mem[fill_q] <= i_data;
    ram_q <= mem[rd_d];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      fill_q    <= '0;
      rd_q      <= '0;
      occ_q     <= '0;
      p_write_q <= '0;
      p_stop_q  <= '0;
      p_int_q   <= '0;
      beat_q    <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      irq_q     <= 2'b11;
    end else begin
      fill_q    <= fill_q + {{(AW-1){1'b0}}, accept};
      rd_q      <= rd_d;
      occ_q     <= occ_d;
      p_write_q <= p_write_d;
      p_stop_q  <= p_stop_d;
      p_int_q   <= p_int_d;
      irq_q     <= {p_stop_d == p_write_d, p_int_d == p_write_d};
      case (state_q)
        IDLE: begin
          if (occ_q >= BLK && p_write_q != p_stop_q)
            state_q <= LOAD;
        end
        LOAD: begin
          out_q   <= ram_q;
          valid_q <= 1'b1;
          last_q  <= 1'b0;
          beat_q  <= '0;
          state_q <= SEND;
        end
        SEND: begin
          if (beat_ok) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              out_q  <= ram_q;
              beat_q <= beat_q + 6'd1;
              last_q <= (beat_q == 6'd62);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pcie_to_pc_fifo.sv
// tb/tb_pcie_to_pc_fifo.sv - directed bench for pcie_to_pc_fifo with beat collector and interrupt tracker
module tb_pcie_to_pc_fifo;
  localparam logic [3:0] STOP = 4'd6;
  localparam logic [3:0] INTA = 4'd7;

  logic        clock, reset;
  logic [1:0]  interrupt;
  logic [31:0] status;
  logic        pio_wvalid;
  logic [63:0] pio_wdata;
  logic [3:0]  pio_addr;
  logic        i_valid;
  logic [63:0] i_data;
  logic        i_ready;
  logic        wr_valid, wr_ready, wr_last;
  logic [63:0] wr_addr, wr_data;

  pcie_to_pc_fifo dut (
    .clock(clock), .reset(reset), .interrupt(interrupt), .status(status),
    .pio_wvalid(pio_wvalid), .pio_wdata(pio_wdata), .pio_addr(pio_addr),
    .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_last(wr_last)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, n_acc = 0, in_waits = 0, valid_cyc = 0, hold_err = 0, stall_cnt = 0;
  int int0_rise = -1, int0_fall = -1, int1_rise = -1;
  int ready_cyc = -1;
  bit bp_en = 0;
  logic [63:0] rx_data[$], rx_addr[$];
  logic        rx_last[$];
  int          rx_cyc[$];

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial forever begin
    @(posedge clock);
    #1;
    if (bp_en) wr_ready = 1'($urandom_range(0, 1));
  end

  // beat collector: records accepted beats and flags any change on the bus during a stall
  initial begin
    logic        prev_stall;
    logic [63:0] prev_data, prev_addr;
    logic        prev_last;
    logic [1:0]  prev_irq;
    prev_stall = 0; prev_data = 0; prev_addr = 0; prev_last = 0; prev_irq = 2'b11;
    forever begin
      @(negedge clock);
      if (wr_valid && prev_stall &&
          (wr_data !== prev_data || wr_addr !== prev_addr || wr_last !== prev_last))
        hold_err++;
      prev_stall = wr_valid && !wr_ready;
      if (prev_stall) stall_cnt++;
      prev_data = wr_data; prev_addr = wr_addr; prev_last = wr_last;
      if (wr_valid) valid_cyc++;
      if (wr_valid && wr_ready) begin
        rx_data.push_back(wr_data);
        rx_addr.push_back(wr_addr);
        rx_last.push_back(wr_last);
        rx_cyc.push_back(cyc);
      end
      if (interrupt[0] && !prev_irq[0]) int0_rise = cyc;
      if (!interrupt[0] && prev_irq[0]) int0_fall = cyc;
      if (interrupt[1] && !prev_irq[1]) int1_rise = cyc;
      prev_irq = interrupt;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got cycle %0d required finish", cyc);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rxd(input int i);
    return (i < rx_data.size()) ? rx_data[i] : '1;
  endfunction
  function automatic logic [63:0] rxa(input int i);
    return (i < rx_addr.size()) ? rx_addr[i] : '1;
  endfunction
  function automatic int rxc(input int i);
    return (i < rx_cyc.size()) ? rx_cyc[i] : -100;
  endfunction
  function automatic int n_lasts();
    int n = 0;
    foreach (rx_last[i]) if (rx_last[i]) n++;
    return n;
  endfunction
  function automatic logic [63:0] pat(input int i);
    return {16'hBEEF, 16'(i), 32'(i * i)};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_rx();
    rx_data.delete(); rx_addr.delete(); rx_last.delete(); rx_cyc.delete();
    n_acc = 0; in_waits = 0; valid_cyc = 0; hold_err = 0; stall_cnt = 0;
  endtask

  task automatic reset_dut();
    reset = 1; i_valid = 0; i_data = 0; pio_wvalid = 0; pio_wdata = 0; pio_addr = 0;
    bp_en = 0; wr_ready = 1;
    step(3);
    reset = 0;
    clear_rx();
  endtask

  task automatic pio_write(input logic [3:0] a, input logic [63:0] d);
    pio_addr = a; pio_wdata = d; pio_wvalid = 1;
    @(posedge clock);
    #1;
    pio_wvalid = 0;
  endtask

  task automatic push(input logic [63:0] d);
    int w;
    w = 0;
    i_valid = 1; i_data = d;
    @(negedge clock);
    while (!i_ready && w < 500) begin
      w++;
      @(negedge clock);
    end
    if (i_ready) begin
      @(posedge clock);
      #1;
      n_acc++;
      i_valid = 0;
    end else begin
      i_valid = 0;
      step(1);
    end
    in_waits += w;
  endtask

  task automatic wait_rx(input int n, input int limit);
    int w;
    w = 0;
    while (rx_data.size() < n && w < limit) begin
      @(negedge clock);
      w++;
    end
    step(1);
  endtask

  initial begin
    int err;
    // 1: reset state, ignored PIO address, one block with p_stop == p_write
    reset_dut();
    @(negedge clock);
    check_eq("rst_wr_valid", wr_valid, 0);
    check_eq("rst_wr_last", wr_last, 0);
    check_eq("rst_i_ready", i_ready, 1);
    check_eq("rst_status", status, 0);
    check_eq("rst_interrupt", interrupt, 2'b11);
    step(1);
    pio_write(4'd5, 64'h400);
    for (int i = 0; i < 64; i++) push(64'(i));
    step(20);
    @(negedge clock);
    check_eq("t1_valid_cycles", valid_cyc, 0);
    check_eq("t1_iready_waits", in_waits, 0);
    check_eq("t1_status", status, 0);
    check_eq("t1_interrupt", interrupt, 2'b11);
    step(1);

    // 2: p_stop=2, two back-to-back requests
    reset_dut();
    pio_write(STOP, 64'h400);
    for (int i = 0; i < 128; i++) push(64'(i));
    wait_rx(128, 400);
    step(5);
    check_eq("t2_beats", rx_data.size(), 128);
    check_eq("t2_addr0", rxa(0), 64'h0);
    check_eq("t2_addr63", rxa(63), 64'h0);
    check_eq("t2_addr64", rxa(64), 64'h200);
    err = 0;
    foreach (rx_data[i]) if (rx_data[i] !== 64'(i)) err++;
    check_eq("t2_data_errs", err, 0);
    check_eq("t2_last63", (rx_last.size() > 63) ? rx_last[63] : 1'b0, 1);
    check_eq("t2_last127", (rx_last.size() > 127) ? rx_last[127] : 1'b0, 1);
    check_eq("t2_last_count", n_lasts(), 2);
    check_eq("t2_burst_span", rxc(63) - rxc(0), 63);
    check_eq("t2_req_gap", rxc(64) - rxc(63), 3);
    @(negedge clock);
    check_eq("t2_status", status, 32'h400);
    check_eq("t2_interrupt", interrupt, 2'b10);
    step(1);

    // 3: fill the ring, then release 8 blocks
    reset_dut();
    fork
      begin
        for (int i = 0; i < 600; i++) push(64'(i));
      end
      begin
        int w;
        w = 0;
        while (n_acc < 512 && w < 2000) begin
          @(negedge clock);
          w++;
        end
        repeat (5) @(negedge clock);
        check_eq("t3_full_iready", i_ready, 0);
        check_eq("t3_full_count", n_acc, 512);
        pio_write(STOP, 64'h1000);
        w = 0;
        while (!i_ready && w < 500) begin
          @(negedge clock);
          w++;
        end
        ready_cyc = cyc;
      end
    join
    wait_rx(512, 3000);
    step(10);
    check_eq("t3_beats", rx_data.size(), 512);
    check_eq("t3_accepted", n_acc, 600);
    check_eq("t3_ready_again", ready_cyc, rxc(63) + 1);
    for (int k = 0; k < 8; k++) check_eq($sformatf("t3_addr_blk%0d", k), rxa(64 * k), 64'(k * 512));
    err = 0;
    foreach (rx_data[i]) if (rx_data[i] !== 64'(i)) err++;
    check_eq("t3_data_errs", err, 0);
    check_eq("t3_last_count", n_lasts(), 8);
    @(negedge clock);
    check_eq("t3_status", status, 32'h1000);
    check_eq("t3_interrupt", interrupt, 2'b10);
    step(1);

    // 4: random backpressure over 4 blocks
    reset_dut();
    pio_write(STOP, 64'h800);
    bp_en = 1;
    for (int i = 0; i < 256; i++) push(pat(i));
    wait_rx(256, 5000);
    bp_en = 0;
    wr_ready = 1;
    step(5);
    check_eq("t4_beats", rx_data.size(), 256);
    err = 0;
    foreach (rx_data[i]) if (rx_data[i] !== pat(i)) err++;
    check_eq("t4_data_errs", err, 0);
    check_eq("t4_last_count", n_lasts(), 4);
    check_eq("t4_hold_errs", hold_err, 0);
    check_eq("t4_stalls_seen", stall_cnt != 0, 1);
    check_eq("t4_addr_blk3", rxa(192), 64'h600);

    // 5: interrupt pointer behaviour
    reset_dut();
    pio_write(INTA, 64'h200);
    pio_write(STOP, 64'h600);
    @(negedge clock);
    check_eq("t5_irq_armed", interrupt, 2'b00);
    step(1);
    int0_rise = -1; int0_fall = -1; int1_rise = -1;
    for (int i = 0; i < 192; i++) push(64'(i + 7));
    wait_rx(192, 600);
    step(5);
    check_eq("t5_beats", rx_data.size(), 192);
    check_eq("t5_int0_rise", int0_rise, rxc(63) + 1);
    check_eq("t5_int0_fall", int0_fall, rxc(127) + 1);
    check_eq("t5_int1_rise", int1_rise, rxc(191) + 1);
    @(negedge clock);
    check_eq("t5_interrupt", interrupt, 2'b10);
    step(1);

    // 6: reset in the middle of a request
    reset_dut();
    pio_write(STOP, 64'h200);
    for (int i = 0; i < 64; i++) push(64'(i));
    wait_rx(30, 200);
    reset = 1;
    @(posedge clock);
    @(negedge clock);
    check_eq("t6_valid_after_rst", wr_valid, 0);
    step(2);
    reset = 0;
    clear_rx();
    @(negedge clock);
    check_eq("t6_status", status, 0);
    check_eq("t6_interrupt", interrupt, 2'b11);
    step(1);
    pio_write(STOP, 64'h200);
    for (int i = 0; i < 64; i++) push(64'(1000 + i));
    wait_rx(64, 300);
    step(5);
    check_eq("t6_beats", rx_data.size(), 64);
    check_eq("t6_addr0", rxa(0), 64'h0);
    check_eq("t6_first_word", rxd(0), 64'd1000);
    err = 0;
    foreach (rx_data[i]) if (rx_data[i] !== 64'(1000 + i)) err++;
    check_eq("t6_data_errs", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
